new_usb_listscheduler: RTL and testbench

- OHCI list-service scheduler for the new_usb host controller.
- Decides which endpoint-descriptor (ED) list the ED fetcher serves next: periodic, control or bulk.
- Enforces the control/bulk service ratio (CBSR), the per-frame periodic window, and clearing of the ControlListFilled/BulkListFilled bits.
- Sits between the operational registers / frame timer and the ED/TD fetch engine.

---
 rtl/new_usb_listscheduler.sv | 166 ++++++++++++++++
 tb/tb_new_usb_listscheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/new_usb_listscheduler.sv
// OHCI list-service scheduler: chooses the next ED list (periodic, control,
// bulk) for the ED fetcher, applies the control/bulk service ratio, tracks
// the per-frame periodic window and generates the ListFilled clear pulses.
module new_usb_listscheduler #(
   parameter int CntWidth = 3
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       ple_i,
   input  logic       cle_i,
   input  logic       ble_i,
   input  logic       clf_i,
   input  logic       blf_i,
   input  logic [1:0] cbsr_i,
   input  logic       sof_i,
   input  logic       periodic_start_i,
   output logic       serve_valid_o,
   output logic [1:0] serve_list_o,
   input  logic       serve_ready_i,
   input  logic       done_valid_i,
   input  logic       done_td_i,
   input  logic       done_end_i,
   output logic       busy_o,
   output logic       clf_clr_o,
   output logic       blf_clr_o,
   output logic       frame_overrun_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

   localparam logic [1:0] ListPer = 2'b00;
   localparam logic [1:0] ListCtl = 2'b01;
   localparam logic [1:0] ListBlk = 2'b10;
   localparam logic [CntWidth-1:0] CntMax = CntWidth'(4);

   state_t              state_q, state_d;
   logic [1:0]          list_q;
   logic [CntWidth-1:0] cnt_q;
   logic                periodic_pending_q, periodic_done_q;
   logic                ctrl_pass_td_q, bulk_pass_td_q;
   logic                clf_clr_q, blf_clr_q, overrun_q;

   logic                ctrl_ok, bulk_ok, pick_bulk;
   logic                pick;
   logic [1:0]          pick_list;
   logic                done_ev, done_ctl, done_blk, done_per;
   logic                per_inflight;
   logic                periodic_done_d, periodic_pending_d;

   assign ctrl_ok   = cle_i & clf_i;
   assign bulk_ok   = ble_i & blf_i;
   // Bulk wins once the control run has exceeded the ratio, or when control
   // has nothing to offer.
   assign pick_bulk = bulk_ok & ((cnt_q > CntWidth'(cbsr_i)) | ~ctrl_ok);

   // Completions only count while an ED is actually in service.
   assign done_ev  = done_valid_i & (state_q == BUSY);
   assign done_ctl = done_ev & (list_q == ListCtl);
   assign done_blk = done_ev & (list_q == ListBlk);
   assign done_per = done_ev & (list_q == ListPer);

   // A periodic ED counts as in flight from request until its completion.
   assign per_inflight = (state_q != IDLE) & (list_q == ListPer);

   // Next-state and list selection; selection only happens in IDLE.
   always_comb begin
      state_d   = state_q;
      pick      = 1'b0;
      pick_list = ListPer;
      case (state_q)
         IDLE: begin
            if (periodic_pending_q) begin
               pick      = 1'b1;
               pick_list = ListPer;
            end else if (pick_bulk) begin
               pick      = 1'b1;
               pick_list = ListBlk;
            end else if (ctrl_ok) begin
               pick      = 1'b1;
               pick_list = ListCtl;
            end
            if (pick) state_d = ISSUE;
         end
         ISSUE:   if (serve_ready_i) state_d = BUSY;
         BUSY:    if (done_valid_i)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Periodic window bookkeeping: SOF effects first, then completion, then
   // a new PeriodicStart may open the window.
   always_comb begin
      periodic_done_d    = periodic_done_q;
      periodic_pending_d = periodic_pending_q;
      if (sof_i) begin
         periodic_done_d    = 1'b0;
         periodic_pending_d = 1'b0;
      end
      if (done_per & done_end_i) begin
         periodic_done_d    = 1'b1;
         periodic_pending_d = 1'b0;
      end
      if (periodic_start_i & ple_i & ~periodic_done_d)
         periodic_pending_d = 1'b1;
   end

   // FSM state and the latched list under service.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         list_q  <= ListPer;
      end else begin
         state_q <= state_d;
         if (pick) list_q <= pick_list;
      end
   end

   // Control-per-bulk ratio counter, saturating.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (done_blk) begin
         cnt_q <= '0;
      end else if (done_ctl && cnt_q != CntMax) begin
         cnt_q <= cnt_q + CntWidth'(1);
      end
   end

   // Per-pass TD tracking; a full pass with no TD clears the Filled bit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ctrl_pass_td_q <= 1'b0;
         bulk_pass_td_q <= 1'b0;
         clf_clr_q      <= 1'b0;
         blf_clr_q      <= 1'b0;
      end else begin
         clf_clr_q <= done_ctl & done_end_i & ~(ctrl_pass_td_q | done_td_i);
         blf_clr_q <= done_blk & done_end_i & ~(bulk_pass_td_q | done_td_i);
         if (done_ctl)
            ctrl_pass_td_q <= done_end_i ? 1'b0 : (ctrl_pass_td_q | done_td_i);
         if (done_blk)
            bulk_pass_td_q <= done_end_i ? 1'b0 : (bulk_pass_td_q | done_td_i);
      end
   end

   // Periodic window registers and overrun pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         periodic_pending_q <= 1'b0;
         periodic_done_q    <= 1'b0;
         overrun_q          <= 1'b0;
      end else begin
         periodic_pending_q <= periodic_pending_d;
         periodic_done_q    <= periodic_done_d;
         overrun_q          <= sof_i & (periodic_pending_q | per_inflight);
      end
   end

   assign serve_valid_o   = (state_q == ISSUE);
   assign serve_list_o    = list_q;
   assign busy_o          = (state_q != IDLE);
   assign clf_clr_o       = clf_clr_q;
   assign blf_clr_o       = blf_clr_q;
   assign frame_overrun_o = overrun_q;

endmodule

// File: tb/tb_new_usb_listscheduler.sv
// Directed bench for new_usb_listscheduler: a scoreboard of expected list
// selections is filled as stimulus is planned and drained at each request.
module tb_new_usb_listscheduler;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       ple_i = 1'b0, cle_i = 1'b0, ble_i = 1'b0, clf_i = 1'b0, blf_i = 1'b0;
   logic [1:0] cbsr_i = 2'd0;
   logic       sof_i = 1'b0, periodic_start_i = 1'b0;
   logic       serve_valid_o;
   logic [1:0] serve_list_o;
   logic       serve_ready_i = 1'b0;
   logic       done_valid_i = 1'b0, done_td_i = 1'b0, done_end_i = 1'b0;
   logic       busy_o, clf_clr_o, blf_clr_o, frame_overrun_o;

   int         tests = 0;
   int         fails = 0;
   logic [1:0] sb[$];
   logic       clf_s, blf_s;

   new_usb_listscheduler #(.CntWidth(3)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .ple_i(ple_i), .cle_i(cle_i),
      .ble_i(ble_i), .clf_i(clf_i), .blf_i(blf_i), .cbsr_i(cbsr_i),
      .sof_i(sof_i), .periodic_start_i(periodic_start_i),
      .serve_valid_o(serve_valid_o), .serve_list_o(serve_list_o),
      .serve_ready_i(serve_ready_i), .done_valid_i(done_valid_i),
      .done_td_i(done_td_i), .done_end_i(done_end_i), .busy_o(busy_o),
      .clf_clr_o(clf_clr_o), .blf_clr_o(blf_clr_o),
      .frame_overrun_o(frame_overrun_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_valid(output bit ok);
      int n;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 50) begin
         if (serve_valid_o === 1'b1) ok = 1'b1;
         else begin
            @(negedge clk_i);
            n++;
         end
      end
      if (!ok) begin
         tests++;
         fails++;
         $error("FAIL wait_valid: got no request within 50 cycles, expected serve_valid_o=1");
      end
   endtask

   task automatic pop_check(input string tag);
      logic [1:0] exp;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s: got request %0h with empty scoreboard, expected none", tag, serve_list_o);
      end else begin
         exp = sb.pop_front();
         chk(tag, serve_list_o, exp);
      end
   endtask

   // Accept one request, hold it in service 3 cycles, then complete it.
   task automatic serve_one(input bit td, input bit en, input bit pstart);
      bit ok;
      wait_valid(ok);
      if (!ok) return;
      pop_check("serve_list");
      serve_ready_i = 1'b1;
      @(negedge clk_i);
      serve_ready_i = 1'b0;
      chk("busy_in_service", busy_o, 1'b1);
      chk("valid_dropped", serve_valid_o, 1'b0);
      periodic_start_i = pstart;
      @(negedge clk_i);
      periodic_start_i = 1'b0;
      @(negedge clk_i);
      done_valid_i = 1'b1;
      done_td_i    = td;
      done_end_i   = en;
      @(negedge clk_i);
      done_valid_i = 1'b0;
      done_td_i    = 1'b0;
      done_end_i   = 1'b0;
      clf_s = clf_clr_o;
      blf_s = blf_clr_o;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, serve_valid_o, 1'b0);
      chk({tag, "_list"}, serve_list_o, 2'b00);
      chk({tag, "_busy"}, busy_o, 1'b0);
      chk({tag, "_clf"}, clf_clr_o, 1'b0);
      chk({tag, "_blf"}, blf_clr_o, 1'b0);
      chk({tag, "_ovr"}, frame_overrun_o, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      // Reset state.
      repeat (2) @(negedge clk_i);
      check_reset_outputs("reset");
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Ratio 3:1 with both lists filled.
      cbsr_i = 2'd2;
      cle_i = 1'b1; ble_i = 1'b1; clf_i = 1'b1; blf_i = 1'b1;
      sb.push_back(2'b01); sb.push_back(2'b01); sb.push_back(2'b01); sb.push_back(2'b10);
      sb.push_back(2'b01); sb.push_back(2'b01); sb.push_back(2'b01); sb.push_back(2'b10);
      for (int i = 0; i < 8; i++) serve_one(1'b1, 1'b0, 1'b0);

      // Control only: counter saturates, then bulk when available.
      blf_i = 1'b0;
      for (int i = 0; i < 6; i++) sb.push_back(2'b01);
      for (int i = 0; i < 6; i++) serve_one(1'b1, 1'b0, 1'b0);
      blf_i = 1'b1; cbsr_i = 2'd3;
      sb.push_back(2'b10);
      serve_one(1'b1, 1'b0, 1'b0);
      cbsr_i = 2'd0;
      sb.push_back(2'b01); sb.push_back(2'b10);
      serve_one(1'b1, 1'b0, 1'b0);
      serve_one(1'b1, 1'b0, 1'b0);

      // ControlListFilled clearing after an empty pass.
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("reset_idle");
      @(negedge clk_i);
      rst_ni = 1'b1;
      ble_i = 1'b0;
      for (int i = 0; i < 3; i++) sb.push_back(2'b01);
      serve_one(1'b0, 1'b0, 1'b0); chk("clf_clr_mid0", clf_s, 1'b0);
      serve_one(1'b0, 1'b0, 1'b0); chk("clf_clr_mid1", clf_s, 1'b0);
      serve_one(1'b0, 1'b1, 1'b0); chk("clf_clr_pulse", clf_s, 1'b1);
      chk("blf_clr_quiet", blf_s, 1'b0);
      clf_i = 1'b0;
      @(negedge clk_i);
      chk("clf_clr_single", clf_clr_o, 1'b0);
      clf_i = 1'b1;
      for (int i = 0; i < 3; i++) sb.push_back(2'b01);
      serve_one(1'b0, 1'b0, 1'b0);
      serve_one(1'b1, 1'b0, 1'b0);
      serve_one(1'b0, 1'b1, 1'b0); chk("clf_clr_td_seen", clf_s, 1'b0);

      // Periodic window opened while a control ED is in service.
      ple_i = 1'b1;
      sb.push_back(2'b01);
      serve_one(1'b1, 1'b0, 1'b1);
      sb.push_back(2'b00); sb.push_back(2'b00); sb.push_back(2'b00);
      serve_one(1'b0, 1'b0, 1'b0);
      serve_one(1'b0, 1'b0, 1'b0);
      serve_one(1'b0, 1'b1, 1'b0);
      sb.push_back(2'b01);
      serve_one(1'b1, 1'b0, 1'b1);
      sb.push_back(2'b01);
      serve_one(1'b1, 1'b0, 1'b0);

      // New frame, periodic list overruns at SOF.
      cle_i = 1'b0;
      sof_i = 1'b1;
      @(negedge clk_i);
      sof_i = 1'b0;
      chk("no_overrun_idle", frame_overrun_o, 1'b0);
      periodic_start_i = 1'b1;
      @(negedge clk_i);
      periodic_start_i = 1'b0;
      sb.push_back(2'b00); sb.push_back(2'b00);
      serve_one(1'b0, 1'b0, 1'b0);
      serve_one(1'b0, 1'b0, 1'b0);
      sof_i = 1'b1;
      @(negedge clk_i);
      sof_i = 1'b0;
      chk("overrun_pulse", frame_overrun_o, 1'b1);
      cle_i = 1'b1;
      @(negedge clk_i);
      chk("overrun_single", frame_overrun_o, 1'b0);
      sb.push_back(2'b00);
      serve_one(1'b0, 1'b0, 1'b0);
      sb.push_back(2'b01);
      serve_one(1'b1, 1'b0, 1'b0);

      // Stalled request, then reset during ISSUE.
      cbsr_i = 2'd0; ble_i = 1'b1; blf_i = 1'b1;
      sb.push_back(2'b10);
      wait_valid(ok);
      if (ok) begin
         pop_check("stall_list");
         for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("stall_valid", serve_valid_o, 1'b1);
            chk("stall_list_hold", serve_list_o, 2'b10);
         end
      end
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("reset_issue");
      @(negedge clk_i);
      rst_ni = 1'b1;
      sb.push_back(2'b01); sb.push_back(2'b10);
      serve_one(1'b1, 1'b0, 1'b0);
      serve_one(1'b1, 1'b0, 1'b0);
      chk("scoreboard_drained", 4'(sb.size()), 4'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
